alu_scheduler: RTL and testbench
================================

// Module: alu_scheduler
// PURPOSE
// Shares one 32-bit ripple-carry adder datapath and the bitwise AND/OR units between two requesters.
// Each request carries an opcode and two operands. A round-robin arbiter grants one request at a time.
// A small FSM sequences the adder: one pass for ADD/SUB/NEG, 32 shift-add passes for MUL.
// The registered result returns on a valid/ready response channel tagged with the requester id.
// PARAMETERS
// WIDTH     32  operand/result width; fixed at 32 to match the ripple adder
// MUL_ITERS 32  shift-add iterations for MUL; must equal WIDTH
// PORTS
// clk          in   1   clock, rising edge
// rst          in   1   asynchronous reset, active-high
// req0_valid   in   1   requester 0 has a request
// req0_ready   out  1   requester 0 request accepted this cycle (when valid)
// req0_op      in   3   requester 0 opcode
// req0_a       in   32  requester 0 operand a
// req0_b       in   32  requester 0 operand b
// req1_valid, req1_ready, req1_op, req1_a, req1_b   same as requester 0, for requester 1
// rsp_valid    out  1   response available
// rsp_ready    in   1   consumer accepts response
// rsp_id       out  1   requester that issued the response
// rsp_result   out  32  result
// rsp_cout     out  1   adder carry-out (ADD/SUB/NEG), else 0
// busy         out  1   high in any state other than IDLE
// BEHAVIOUR
// - Opcodes:
//   000 ADD  a+b, cin=0
//   001 SUB  a+~b, cin=1
//   010 AND  a&b
//   011 OR   a|b
//   100 NEG  ~a+1
//   101 MUL  low 32 bits of a*b
//   110/111 illegal: result 0, cout 0, still responded to
// - Reset (async): state=IDLE, rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_id=0, rr pointer=req0.
//   req*_ready=0 while rst high. An in-flight op is dropped with no response.
// - FSM states:
//   IDLE -> EXEC (single-pass ops) or MUL (MUL), on request accept.
//   EXEC -> RESP after 1 cycle.
//   MUL  -> RESP after 32 cycles.
//   RESP -> IDLE on rsp_valid & rsp_ready.
// - Arbitration:
//   - Only in IDLE: grant_i requires req_i_valid.
//   - If both requesters are valid, grant the rr pointer side.
//   - ready_i = IDLE & grant_i (combinational); at most one ready is high.
//   - On accept, latch op/a/b/id; the pointer moves to the other requester.
//   - A lone valid requester is granted regardless of the pointer; the pointer still flips.
// - Requesters hold valid, op, a and b stable until ready; valid never drops before ready.
// - Latency:
//   - Accept in cycle N -> rsp_valid in cycle N+2 for single-pass ops.
//   - MUL: rsp_valid in cycle N+33.
// - MUL:
//   - acc=0, i=0.
//   - Each cycle: if b[i], acc = acc + (a<<i), using the shared adder with cin=0; i++.
//   - Overflow beyond bit 31 is discarded; rsp_cout=0.
// - RESP: rsp_valid, rsp_id, rsp_result and rsp_cout are held stable until rsp_ready.
//   After the handshake, IDLE follows next cycle; there is no accept in the same cycle as the response handshake.
// - No new request is accepted while busy; a valid requester simply waits.
// - Arithmetic wraps modulo 2^32; signedness is interpreted by the consumer.
// TESTING
// - ADD via req0: a=43, b=20 -> rsp_result=63, rsp_cout=0, rsp_id=0, rsp_valid at accept+2.
// - SUB via req1: a=9, b=10 -> rsp_result=32'hFFFFFFFF, cout=0.
//   Also a=123, b=120 -> rsp_result=3, cout=1.
// - NEG a=1 -> 32'hFFFFFFFF, cout=0. MUL a=123, b=120 -> 14760, rsp_valid at accept+33, busy high throughout.
// - Both valid every cycle, rsp_ready=1 -> grants alternate: req0, req1, req0, req1 (ids in rsp_id order).
// - rsp_ready held 0 for 5 cycles -> response held stable, both readys 0, no new accept.
//   Release -> IDLE next cycle.
// - Assert rst mid-MUL (iteration 10) -> outputs return to reset values immediately, no response emitted.
//   After release, req0 is granted first.

Source files
------------

// File: rtl/alu_scheduler.sv
// Two-requester ALU front end: round-robin grant into a shared ripple-carry adder,
// with a shift-add sequencer for MUL and a held valid/ready response register.
module alu_scheduler #(
    parameter int WIDTH     = 32,
    parameter int MUL_ITERS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             busy
);
    localparam int CW = $clog2(MUL_ITERS);

    typedef enum logic [1:0] {IDLE, EXEC, MULT, RESP} state_t;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
        OP_OR  = 3'b011, OP_NEG = 3'b100, OP_MUL = 3'b101
    } op_t;

    state_t           state, state_nx;
    op_t              op_r;
    logic [WIDTH-1:0] a_r, b_r, acc;
    logic [CW-1:0]    cnt;
    logic             id_r, rr;
    logic             grant0, grant1, accept;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] add_x, add_y, add_sum;
    logic             add_cin, add_cout;

    // rst gates the readys so nothing is accepted while reset is held
    always_comb begin
        grant0 = (state == IDLE) && !rst && req0_valid && (!req1_valid || !rr);
        grant1 = (state == IDLE) && !rst && req1_valid && (!req0_valid || rr);
        accept = grant0 || grant1;
        sel_op = grant1 ? req1_op : req0_op;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        add_x   = a_r;
        add_y   = b_r;
        add_cin = 1'b0;
        if (state == MULT) begin
            add_x = acc;
            add_y = b_r[cnt] ? (a_r << cnt) : '0;
        end else begin
            case (op_r)
                OP_SUB: begin
                    add_y   = ~b_r;
                    add_cin = 1'b1;
                end
                OP_NEG: begin
                    add_x   = ~a_r;
                    add_y   = '0;
                    add_cin = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin : ripple
        logic c;
        c       = add_cin;
        add_sum = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            add_sum[i] = add_x[i] ^ add_y[i] ^ c;
            c          = (add_x[i] & add_y[i]) | (c & (add_x[i] ^ add_y[i]));
        end
        add_cout = c;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (sel_op == OP_MUL) ? MULT : EXEC;
            EXEC: state_nx = RESP;
            MULT: if (cnt == CW'(MUL_ITERS - 1)) state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_r       <= OP_ADD;
            a_r        <= '0;
            b_r        <= '0;
            acc        <= '0;
            cnt        <= '0;
            id_r       <= 1'b0;
            rr         <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (accept) begin
                    op_r <= op_t'(sel_op);
                    a_r  <= grant1 ? req1_a : req0_a;
                    b_r  <= grant1 ? req1_b : req0_b;
                    id_r <= grant1;
                    rr   <= ~rr;
                    acc  <= '0;
                    cnt  <= '0;
                end
                EXEC: begin
                    rsp_id <= id_r;
                    case (op_r)
                        OP_ADD, OP_SUB, OP_NEG: begin
                            rsp_result <= add_sum;
                            rsp_cout   <= add_cout;
                        end
                        OP_AND: begin
                            rsp_result <= a_r & b_r;
                            rsp_cout   <= 1'b0;
                        end
                        OP_OR: begin
                            rsp_result <= a_r | b_r;
                            rsp_cout   <= 1'b0;
                        end
                        default: begin
                            rsp_result <= '0;
                            rsp_cout   <= 1'b0;
                        end
                    endcase
                end
                MULT: begin
                    acc <= add_sum;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(MUL_ITERS - 1)) begin
                        rsp_result <= add_sum;
                        rsp_cout   <= 1'b0;
                        rsp_id     <= id_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: vector table plus arbitration, backpressure and reset sequences.
module tb_alu_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
    logic [31:0] rsp_result;

    int checks = 0;
    int errors = 0;
    logic exp_rr;

    alu_scheduler #(.WIDTH(32), .MUL_ITERS(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        cout;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // counts negedges until rsp_valid; returns 1000 on timeout
    task automatic wait_rsp(output int n, output logic busy_ok);
        n = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (!rsp_valid && !busy) busy_ok = 1'b0;
        end while (!rsp_valid && n < 100);
        if (!rsp_valid) n = 1000;
    endtask

    task automatic do_req(input vec_t v, input int idx);
        int   n;
        logic rdy;
        logic bok;
        @(negedge clk);
        rsp_ready = 1'b1;
        drive(v.id, v.op, v.a, v.b);
        n = 0;
        #1 rdy = v.id ? req1_ready : req0_ready;
        while (!rdy && n < 50) begin
            @(negedge clk);
            #1 rdy = v.id ? req1_ready : req0_ready;
            n++;
        end
        chk($sformatf("v%0d_ready", idx), {31'b0, rdy}, 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_rr = ~exp_rr;
        wait_rsp(n, bok);
        chk($sformatf("v%0d_latency", idx), n, v.lat);
        chk($sformatf("v%0d_result", idx), rsp_result, v.res);
        chk($sformatf("v%0d_cout", idx), {31'b0, rsp_cout}, {31'b0, v.cout});
        chk($sformatf("v%0d_id", idx), {31'b0, rsp_id}, {31'b0, v.id});
        chk($sformatf("v%0d_busy", idx), {31'b0, bok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   n;
        int   got;
        logic bok;
        logic exp_id;

        vecs[0]  = '{1'b0, 3'b000, 32'd43,         32'd20,         32'd63,         1'b0, 2};
        vecs[1]  = '{1'b1, 3'b001, 32'd9,          32'd10,         32'hFFFFFFFF,   1'b0, 2};
        vecs[2]  = '{1'b1, 3'b001, 32'd123,        32'd120,        32'd3,          1'b1, 2};
        vecs[3]  = '{1'b0, 3'b100, 32'd1,          32'd0,          32'hFFFFFFFF,   1'b0, 2};
        vecs[4]  = '{1'b0, 3'b101, 32'd123,        32'd120,        32'd14760,      1'b0, 33};
        vecs[5]  = '{1'b1, 3'b010, 32'hF0F01234,   32'h0FF0FFFF,   32'h00F01234,   1'b0, 2};
        vecs[6]  = '{1'b0, 3'b011, 32'h0F000000,   32'h000000F0,   32'h0F0000F0,   1'b0, 2};
        vecs[7]  = '{1'b1, 3'b000, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, 2};
        vecs[8]  = '{1'b0, 3'b110, 32'd5,          32'd6,          32'd0,          1'b0, 2};
        vecs[9]  = '{1'b1, 3'b101, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0, 33};
        vecs[10] = '{1'b0, 3'b100, 32'd0,          32'd0,          32'd0,          1'b1, 2};
        vecs[11] = '{1'b1, 3'b111, 32'd77,         32'd88,         32'd0,          1'b0, 2};

        rst = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 3'b000; req1_a = '0; req1_b = '0;
        exp_rr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_cout", {31'b0, rsp_cout}, 32'd0);
        chk("rst_id", {31'b0, rsp_id}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
        req0_valid = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) do_req(vecs[i], i);

        // both requesters always valid: responses must alternate from the pointer side
        @(negedge clk);
        rsp_ready = 1'b1;
        drive(1'b0, 3'b000, 32'd1, 32'd1);
        drive(1'b1, 3'b000, 32'd5, 32'd5);
        exp_id = exp_rr;
        got = 0;
        n = 0;
        while (got < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (rsp_valid) begin
                chk($sformatf("rr%0d_id", got), {31'b0, rsp_id}, {31'b0, exp_id});
                chk($sformatf("rr%0d_result", got), rsp_result, exp_id ? 32'd10 : 32'd2);
                exp_id = ~exp_id;
                got++;
            end
        end
        chk("rr_count", got, 4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;

        // response backpressure
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(1'b0, 3'b000, 32'd7, 32'd8);
        #1 chk("bp_ready0", {31'b0, req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        drive(1'b1, 3'b000, 32'd1, 32'd2);
        wait_rsp(n, bok);
        chk("bp_latency", n, 2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), {31'b0, rsp_valid}, 32'd1);
            chk($sformatf("bp%0d_result", k), rsp_result, 32'd15);
            chk($sformatf("bp%0d_id", k), {31'b0, rsp_id}, 32'd0);
            chk($sformatf("bp%0d_readys", k), {30'b0, req1_ready, req0_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_busy", {31'b0, busy}, 32'd0);
        chk("bp_release_ready1", {31'b0, req1_ready}, 32'd1);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        wait_rsp(n, bok);
        chk("bp_next_latency", n, 2);
        chk("bp_next_result", rsp_result, 32'd3);
        chk("bp_next_id", {31'b0, rsp_id}, 32'd1);
        @(posedge clk);
        #1;

        // reset in the middle of a MUL
        @(negedge clk);
        drive(1'b0, 3'b101, 32'd123, 32'd120);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mul_mid_busy", {31'b0, busy}, 32'd1);
        drive(1'b0, 3'b000, 32'd2, 32'd3);
        drive(1'b1, 3'b000, 32'd4, 32'd4);
        #2 rst = 1'b1;
        #1;
        chk("mrst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_result", rsp_result, 32'd0);
        chk("mrst_readys", {30'b0, req1_ready, req0_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("mrst_hold_valid", {31'b0, rsp_valid}, 32'd0);
        rst = 1'b0;
        #1 chk("mrst_first_grant", {30'b0, req1_ready, req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(n, bok);
        chk("mrst_rsp_id", {31'b0, rsp_id}, 32'd0);
        chk("mrst_rsp_result", rsp_result, 32'd5);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
